isqrt_rr_arbiter: RTL
=====================

# isqrt_rr_arbiter

Round-robin arbiter that shares one pipelined `isqrt` unit among `N_REQ` independent requesters, e.g. several formula FSMs in one top. It grants at most one square-root request per cycle and records the owner of each issued request in an in-order tag FIFO. Each returning `isqrt` result is routed to the requester that issued it. The block sits between the requester FSMs and the `isqrt` instance. It drives the `isqrt` input side and consumes its output side.

## Interface
- `N_REQ`, default 3: number of requesters, 2..8.
- `TAG_DEPTH`, default 16: tag FIFO depth; power of two; must be ≥ `isqrt` latency + 1 for full throughput.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_vld`  in  N_REQ  per-requester request valid.
- `req_x`  in  N_REQ*32  per-requester operand; slice i = bits [32*i+31:32*i].
- `req_rdy`  out  N_REQ  one-hot grant; request i accepted when `req_vld[i] & req_rdy[i]`.
- `isqrt_x_vld`  out  1  operand valid to `isqrt`.
- `isqrt_x`  out  32  operand to `isqrt`.
- `isqrt_y_vld`  in  1  result valid from `isqrt`.
- `isqrt_y`  in  16  result from `isqrt`.
- `rsp_vld`  out  N_REQ  one-hot result valid, routed to the owning requester.
- `rsp_y`  out  16  result, shared by all requesters; qualified by `rsp_vld`.
- `busy`  out  1  at least one request is outstanding (tag FIFO non-empty).
- `err`  out  1  sticky flag: a result arrived with no outstanding tag.

## Operation
- **Round-robin pointer `last`** (log2 N_REQ bits) holds the most recently granted index.
  - Search order is `last+1`, `last+2`, … with wrap.
  - The first requester with `req_vld` set is the candidate.
- **Grant:**
  - `req_rdy` is combinational: candidate bit set iff `count < TAG_DEPTH`, otherwise all zero.
  - At most one bit of `req_rdy` is high.
  - `req_rdy` is 0 for requesters without `req_vld`.
- **On accept of requester g:**
  - `isqrt_x_vld <= 1` and `isqrt_x <= req_x[g]`, registered.
  - Push tag g into the FIFO.
  - `last <= g`.
- **No accept:** `isqrt_x_vld <= 0`; `isqrt_x` holds its last value.
- **Tag FIFO:**
  - Circular buffer with write pointer, read pointer and `count` (0..TAG_DEPTH).
  - Both pointers wrap modulo `TAG_DEPTH`.
- **On `isqrt_y_vld` with `count > 0`:**
  - Pop tag t.
  - `rsp_vld <= onehot(t)` and `rsp_y <= isqrt_y`, registered.
- **On `isqrt_y_vld` with `count == 0`:** no pop, `rsp_vld <= 0`, `err <= 1`.
- **Simultaneous push and pop:** `count` is unchanged; both pointers advance.
- **Full FIFO:**
  - No grant is issued while `count == TAG_DEPTH`.
  - A pop in that same cycle does not enable a grant; the grant resumes next cycle.
- **`err` and `busy`:**
  - `err` is cleared only by reset.
  - `busy = (count != 0)`.
- **Results are strictly in order:** `isqrt` is an in-order pipeline, so the tag order equals the result order.

## Timing
- **Reset** (async assert, sync-released internally):
  - `isqrt_x_vld`, `rsp_vld`, `err` and `count` = 0.
  - `isqrt_x` and `rsp_y` = 0.
  - Pointers = 0.
  - `last = N_REQ-1`, so requester 0 has first priority.
- **Reset mid-operation:**
  - All outstanding tags are discarded.
  - Results arriving after release with `count == 0` set `err`. The integrator resets `isqrt` together with this block.
- **Accept → `isqrt_x_vld` latency:** accept in cycle T gives `isqrt_x_vld = 1` in cycle T+1, for exactly one cycle per accept.
- **Result → response latency:** `isqrt_y_vld` in cycle R gives `rsp_vld` in cycle R+1, for exactly one cycle.
- **Throughput:** one grant per cycle while requests are pending and `count < TAG_DEPTH`.
- **Requester rules:**
  - A requester holds `req_vld` and `req_x` stable until accepted.
  - It may deassert `req_vld` before acceptance without effect.

## Test plan
- **Single request:** reset, `req_vld[0]=1`, `req_x[0]=16`.
  - Expect `req_rdy=3'b001` in cycle 0 and `isqrt_x=16` valid in cycle 1.
  - Later expect `rsp_vld=3'b001`, `rsp_y=4`, with `busy` falling after the response.
- **Simultaneous requests:** all three assert in the same cycle with x=100, 49, 9.
  - Expect grants 0, 1, 2 in three consecutive cycles.
  - Expect responses in order: `rsp_vld` 001/`rsp_y=10`, 010/7, 100/3.
- **Fairness:** requesters 0 and 2 hold `req_vld` continuously, each re-asserting after accept.
  - Expect the grant sequence 0, 2, 0, 2 and never two consecutive grants to the same index.
- **Full FIFO:** `TAG_DEPTH=2` with a bench `isqrt` model of latency 6 and requester 1 continuously valid.
  - Expect exactly 2 grants, then `req_rdy=0` until the first `isqrt_y_vld`.
  - Expect the next grant one cycle after that pop.
- **Spurious result:** after reset with no requests, pulse `isqrt_y_vld`, `isqrt_y=5`.
  - Expect `rsp_vld=0`.
  - Expect `err=1` from the next cycle, staying 1 until reset.
- **Reset mid-flight:** assert `rst=0` while `count=3`.
  - Expect all outputs 0 immediately and `busy=0`.
  - After release, a new request x=81 returns `rsp_y=9` to the correct requester.

Source files
------------

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin front end for one shared pipelined isqrt unit.
// Grants one requester per cycle and records the owner in an in-order tag
// FIFO. Each returning result is steered back to the requester that issued it.

// One response lane: raises its rsp_vld bit when the popped tag names it.
module isqrt_rr_lane #(
  parameter int LW  = 2,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pop,
  input  logic [LW-1:0] tag,
  output logic          hit
);
  // registered one-hot response bit for this requester
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hit <= 1'b0;
    else        hit <= pop && (tag == LW'(IDX));
endmodule

module isqrt_rr_arbiter #(
  parameter int N_REQ     = 3,
  parameter int TAG_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_vld,
  input  logic [N_REQ*32-1:0]  req_x,
  output logic [N_REQ-1:0]     req_rdy,
  output logic                 isqrt_x_vld,
  output logic [31:0]          isqrt_x,
  input  logic                 isqrt_y_vld,
  input  logic [15:0]          isqrt_y,
  output logic [N_REQ-1:0]     rsp_vld,
  output logic [15:0]          rsp_y,
  output logic                 busy,
  output logic                 err
);
  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [1:0]                rst_sync;
  logic                      rst_n_i;
  logic [N_REQ-1:0][31:0]    x_arr;
  logic [LW-1:0]             last;
  logic [LW-1:0]             cand;
  logic                      found;
  int                        idx;
  logic                      full;
  logic                      grant;
  logic                      pop;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             count;
  logic [LW-1:0]             tag_mem [TAG_DEPTH];

  assign x_arr = req_x;

  // reset asserts asynchronously, releases on the second clock edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};

  assign rst_n_i = rst_sync[1];

  // round-robin search starting just after the last granted index
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req_vld[idx]) begin
        found = 1'b1;
        cand  = LW'(idx);
      end
    end
  end

  // a pop in the full cycle does not free a slot until the next cycle
  assign full    = (count == CW'(TAG_DEPTH));
  assign grant   = found && !full && rst_n_i;
  assign req_rdy = grant ? (N_REQ'(1) << cand) : '0;
  assign pop     = isqrt_y_vld && (count != '0);
  assign busy    = (count != '0);

  // issue path, FIFO pointers/count, response data and sticky error
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      isqrt_x_vld <= 1'b0;
      isqrt_x     <= '0;
      last        <= LW'(N_REQ - 1);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rsp_y       <= '0;
      err         <= 1'b0;
    end else begin
      isqrt_x_vld <= grant;
      if (grant) begin
        isqrt_x <= x_arr[cand];
        last    <= cand;
        wr_ptr  <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rsp_y  <= isqrt_y;
      end
      count <= count + CW'(grant) - CW'(pop);
      if (isqrt_y_vld && count == '0) err <= 1'b1;
    end

  // tag storage; contents are don't-care until written
  always_ff @(posedge clk)
    if (grant) tag_mem[wr_ptr] <= cand;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    isqrt_rr_lane #(.LW(LW), .IDX(i)) u_lane (
      .clk   (clk),
      .rst_n (rst_n_i),
      .pop   (pop),
      .tag   (tag_mem[rd_ptr]),
      .hit   (rsp_vld[i])
    );
  end
endmodule
